mult_arbiter: RTL

MULT_ARBITER -- requirements
Module: mult_arbiter

---
 rtl/mult_arbiter_pkg.sv | 8 +
 rtl/mult_arbiter_if.sv | 30 +++
 rtl/mult_arbiter_rr_arbiter2.sv | 14 +
 rtl/mult_arbiter.sv | 76 +++++++
 4 files changed

// File: rtl/mult_arbiter_pkg.sv
// mult_arbiter_pkg: state encoding and parameter defaults shared by the multiply arbiter files
package mult_arbiter_pkg;
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;
   localparam int WD_LIMIT_DEF = 15;
   localparam int TAG_W_DEF    = 5;
endpackage

// File: rtl/mult_arbiter_if.sv
// mult_arbiter_if: requester, response and multiplier-side signals of the multiply arbiter
interface mult_arbiter_if
   import mult_arbiter_pkg::*;
#(
   parameter int TAG_W = TAG_W_DEF
) ();
   logic             req0_valid, req1_valid, req0_ready, req1_ready;
   logic [31:0]      req0_a, req1_a;
   logic [15:0]      req0_b, req1_b;
   logic [TAG_W-1:0] req0_tag, req1_tag;
   logic             flush, busy;
   logic             resp_valid, resp_id, resp_exception;
   logic [TAG_W-1:0] resp_tag;
   logic [31:0]      resp_result;
   logic             mult_ctrl, mult_exception, mult_inputRDY, mult_resultRDY;
   logic [31:0]      mult_a, mult_result;
   logic [15:0]      mult_b;
   modport slave (
      input  req0_valid, req1_valid, req0_a, req1_a, req0_b, req1_b, req0_tag, req1_tag, flush,
      input  mult_result, mult_exception, mult_inputRDY, mult_resultRDY,
      output req0_ready, req1_ready, busy, resp_valid, resp_id, resp_tag, resp_result, resp_exception,
      output mult_ctrl, mult_a, mult_b
   );
   modport master (
      output req0_valid, req1_valid, req0_a, req1_a, req0_b, req1_b, req0_tag, req1_tag, flush,
      output mult_result, mult_exception, mult_inputRDY, mult_resultRDY,
      input  req0_ready, req1_ready, busy, resp_valid, resp_id, resp_tag, resp_result, resp_exception,
      input  mult_ctrl, mult_a, mult_b
   );
endinterface

// File: rtl/mult_arbiter_rr_arbiter2.sv
// rr_arbiter2: two-way round-robin grant; the pointer moves to the loser after each advance
module rr_arbiter2 (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [1:0] req_i,
   input  logic       adv_i,
   output logic [1:0] gnt_o
);
   logic ptr_q, ptr_d;
   assign gnt_o[0] = req_i[0] && (!req_i[1] || !ptr_q);
   assign gnt_o[1] = req_i[1] && (!req_i[0] || ptr_q);
   assign ptr_d    = adv_i ? gnt_o[0] : ptr_q;
   always_ff @(posedge clk_i) ptr_q <= rst_i ? 1'b0 : ptr_d;
endmodule

// File: rtl/mult_arbiter.sv
// mult_arbiter: serialises two requesters onto one multiplier with round-robin grant,
// watchdog abort and a single-cycle response strobe.
module mult_arbiter
   import mult_arbiter_pkg::*;
#(
   parameter int WD_LIMIT = WD_LIMIT_DEF,
   parameter int TAG_W    = TAG_W_DEF
) (
   input logic           clock,
   input logic           reset,
   mult_arbiter_if.slave bus
);
   logic [1:0]       state_q, state_d, gnt;
   logic [31:0]      a_q, a_d, res_q, res_d;
   logic [15:0]      b_q, b_d;
   logic [TAG_W-1:0] tag_q, tag_d;
   logic [3:0]       wd_q, wd_d;
   logic             id_q, id_d, exc_q, exc_d;
   logic             accept, run, abort, finish, resp_v;
   assign run    = state_q == RUN;
   assign accept = state_q == IDLE && (bus.req0_valid || bus.req1_valid) && bus.mult_inputRDY
                   && !bus.flush && !reset;
   // an exception outranks a simultaneous resultRDY, so abort is tested first
   assign abort  = bus.mult_exception || wd_q == 4'(WD_LIMIT - 1);
   assign finish = run && (abort || bus.mult_resultRDY);
   rr_arbiter2 u_rr (
      .clk_i(clock),
      .rst_i(reset),
      .req_i({bus.req1_valid, bus.req0_valid}),
      .adv_i(accept),
      .gnt_o(gnt)
   );
   always_comb begin
      state_d = bus.flush ? IDLE : accept ? RUN : finish ? DONE : state_q == DONE ? IDLE : state_q;
      a_d     = accept ? (gnt[1] ? bus.req1_a : bus.req0_a) : a_q;
      b_d     = accept ? (gnt[1] ? bus.req1_b : bus.req0_b) : b_q;
      tag_d   = accept ? (gnt[1] ? bus.req1_tag : bus.req0_tag) : tag_q;
      id_d    = accept ? gnt[1] : id_q;
      wd_d    = accept ? 4'd0 : (run && wd_q != 4'hF) ? wd_q + 4'd1 : wd_q;
      res_d   = finish ? (abort ? 32'd0 : bus.mult_result) : res_q;
      exc_d   = finish ? abort : exc_q;
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         tag_q   <= '0;
         id_q    <= 1'b0;
         wd_q    <= '0;
         res_q   <= '0;
         exc_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         tag_q   <= tag_d;
         id_q    <= id_d;
         wd_q    <= wd_d;
         res_q   <= res_d;
         exc_q   <= exc_d;
      end
   end
   assign resp_v             = state_q == DONE && !bus.flush;
   assign bus.resp_valid     = resp_v;
   assign bus.resp_id        = resp_v && id_q;
   assign bus.resp_exception = resp_v && exc_q;
   assign bus.resp_tag       = resp_v ? tag_q : '0;
   assign bus.resp_result    = resp_v ? res_q : '0;
   assign bus.req0_ready     = accept && gnt[0];
   assign bus.req1_ready     = accept && gnt[1];
   assign bus.busy           = state_q != IDLE;
   assign bus.mult_ctrl      = run;
   assign bus.mult_a         = a_q;
   assign bus.mult_b         = b_q;
endmodule
